// File: rtl/vericade_pkg.sv
// Shared types and constants for the arcade session manager.
package vericade_pkg;

  typedef enum logic [1:0] {
    ST_BLANK   = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_ATTRACT = 2'd2
  } state_t;

  localparam int GRID_W = 64;
  localparam int LED_W  = 16;
  localparam int BTN_W  = 5;

  localparam logic [GRID_W-1:0] ATTRACT_SEED = 64'h8040201008040201;

  // Rotate the 8x8 grid left by one row (8 bits).
  function automatic logic [GRID_W-1:0] rotl_row(input logic [GRID_W-1:0] g);
    return {g[GRID_W-9:0], g[GRID_W-1:GRID_W-8]};
  endfunction

endpackage

// File: rtl/attract_pattern_gen.sv
// Attract-mode grid pattern: seeded on load, rotated one row every ATTRACT_STEP cycles while running.
module attract_pattern_gen
  import vericade_pkg::*;
#(
  parameter int ATTRACT_STEP = 5_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              run,
  output logic [GRID_W-1:0] pattern
);

  localparam int STEP_W = (ATTRACT_STEP > 1) ? $clog2(ATTRACT_STEP) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(ATTRACT_STEP - 1);

  logic [STEP_W-1:0] step_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_cnt <= '0;
      pattern  <= '0;
    end else if (load) begin
      step_cnt <= '0;
      pattern  <= ATTRACT_SEED;
    end else if (run) begin
      if (step_cnt == STEP_LAST) begin
        step_cnt <= '0;
        pattern  <= rotl_row(pattern);
      end else begin
        step_cnt <= step_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/arcade_session_mgr.sv
// Arcade session manager: selects the running game, blanks the display on switches,
// tracks per-game high scores and falls back to an attract pattern when idle.
module arcade_session_mgr
  import vericade_pkg::*;
#(
  parameter int          NUM_GAMES    = 4,
  parameter int          SEL_W        = $clog2(NUM_GAMES),
  parameter int          SCORE_W      = 8,
  parameter int          BLANK_CYCLES = 1024,
  parameter logic [31:0] IDLE_CYCLES  = 32'd1_500_000_000,
  parameter int          ATTRACT_STEP = 5_000_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SEL_W-1:0]             game_select,
  input  logic [BTN_W-1:0]             btn_pulse,
  input  logic [NUM_GAMES*LED_W-1:0]   led_in,
  input  logic [NUM_GAMES*GRID_W-1:0]  grid_in,
  input  logic [NUM_GAMES*SCORE_W-1:0] score_in,
  output logic [NUM_GAMES-1:0]         game_en,
  output logic [NUM_GAMES-1:0]         game_rst_req,
  output logic [BTN_W-1:0]             btn_out,
  output logic [LED_W-1:0]             led_out,
  output logic [GRID_W-1:0]            grid_out,
  output logic [SCORE_W-1:0]           score_out,
  output logic [SCORE_W-1:0]           high_score,
  output logic [SEL_W-1:0]             active_game,
  output logic [1:0]                   state_o
);

  localparam int IDX_W = $clog2(NUM_GAMES);
  localparam int BLK_W = $clog2(BLANK_CYCLES);
  localparam logic [BLK_W-1:0]     BLANK_LAST = BLK_W'(BLANK_CYCLES - 1);
  localparam logic [31:0]          IDLE_LAST  = IDLE_CYCLES - 32'd1;
  localparam logic [SEL_W:0]       NUM_G      = (SEL_W+1)'(NUM_GAMES);
  localparam logic [NUM_GAMES-1:0] GAME_ONE   = NUM_GAMES'(1);

  state_t               state, state_nxt;
  logic [SEL_W-1:0]     target, target_nxt, active_nxt;
  logic [BLK_W-1:0]     blank_cnt, blank_nxt;
  logic [31:0]          idle_cnt, idle_nxt;
  logic [NUM_GAMES-1:0] rst_req_nxt;
  logic                 boot;
  logic                 sel_legal, switch_req;
  logic                 pat_load, pat_run;
  logic [GRID_W-1:0]    pattern;
  logic [IDX_W-1:0]     act_idx;

  logic [LED_W-1:0]   led_slot   [NUM_GAMES];
  logic [GRID_W-1:0]  grid_slot  [NUM_GAMES];
  logic [SCORE_W-1:0] score_slot [NUM_GAMES];
  logic [SCORE_W-1:0] hs_tbl     [NUM_GAMES];

  always_comb begin
    for (int g = 0; g < NUM_GAMES; g++) begin
      led_slot[g]   = led_in[g*LED_W +: LED_W];
      grid_slot[g]  = grid_in[g*GRID_W +: GRID_W];
      score_slot[g] = score_in[g*SCORE_W +: SCORE_W];
    end
  end

  assign act_idx    = IDX_W'(active_game);
  assign sel_legal  = {1'b0, game_select} < NUM_G;
  assign switch_req = sel_legal && (game_select != active_game);
  assign state_o    = state;
  assign game_en    = (state == ST_ACTIVE) ? (GAME_ONE << active_game) : '0;

  // boot makes the first edge after reset behave like a fresh entry into BLANK.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_BLANK;
      target      <= '0;
      active_game <= '0;
      blank_cnt   <= '0;
      idle_cnt    <= '0;
      boot        <= 1'b1;
    end else begin
      state       <= state_nxt;
      target      <= target_nxt;
      active_game <= active_nxt;
      blank_cnt   <= blank_nxt;
      idle_cnt    <= idle_nxt;
      boot        <= 1'b0;
    end
  end

  always_comb begin
    state_nxt   = state;
    target_nxt  = target;
    active_nxt  = active_game;
    blank_nxt   = blank_cnt;
    idle_nxt    = '0;
    rst_req_nxt = '0;
    case (state)
      ST_BLANK: begin
        if (sel_legal && (game_select != target)) begin
          target_nxt  = game_select;
          blank_nxt   = '0;
          rst_req_nxt = GAME_ONE << game_select;
        end else if (boot) begin
          blank_nxt   = '0;
          rst_req_nxt = GAME_ONE << target;
        end else if (blank_cnt == BLANK_LAST) begin
          state_nxt  = ST_ACTIVE;
          active_nxt = target;
          blank_nxt  = '0;
        end else begin
          blank_nxt = blank_cnt + 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (switch_req) begin
          state_nxt   = ST_BLANK;
          target_nxt  = game_select;
          blank_nxt   = '0;
          rst_req_nxt = GAME_ONE << game_select;
        end else if (|btn_pulse) begin
          idle_nxt = '0;
        end else if (idle_cnt == IDLE_LAST) begin
          state_nxt = ST_ATTRACT;
        end else begin
          idle_nxt = idle_cnt + 32'd1;
        end
      end
      ST_ATTRACT: begin
        // A select change outranks the wake-up button; the button itself is swallowed.
        if (switch_req) begin
          state_nxt   = ST_BLANK;
          target_nxt  = game_select;
          blank_nxt   = '0;
          rst_req_nxt = GAME_ONE << game_select;
        end else if (|btn_pulse) begin
          state_nxt = ST_ACTIVE;
        end
      end
      default: state_nxt = ST_BLANK;
    endcase
  end

  assign pat_load = (state == ST_ACTIVE) && (state_nxt == ST_ATTRACT);
  assign pat_run  = (state == ST_ATTRACT);

  attract_pattern_gen #(.ATTRACT_STEP(ATTRACT_STEP)) u_attract (
    .clk     (clk),
    .rst     (rst),
    .load    (pat_load),
    .run     (pat_run),
    .pattern (pattern)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      game_rst_req <= '0;
      btn_out      <= '0;
      led_out      <= '0;
      grid_out     <= '0;
      score_out    <= '0;
      high_score   <= '0;
      for (int g = 0; g < NUM_GAMES; g++) hs_tbl[g] <= '0;
    end else begin
      game_rst_req <= rst_req_nxt;
      high_score   <= hs_tbl[act_idx];
      case (state)
        ST_ACTIVE: begin
          btn_out   <= btn_pulse;
          led_out   <= led_slot[act_idx];
          grid_out  <= grid_slot[act_idx];
          score_out <= score_slot[act_idx];
          if (score_slot[act_idx] > hs_tbl[act_idx]) hs_tbl[act_idx] <= score_slot[act_idx];
        end
        ST_ATTRACT: begin
          btn_out   <= '0;
          led_out   <= '0;
          grid_out  <= pattern;
          score_out <= hs_tbl[act_idx];
        end
        default: begin
          btn_out   <= '0;
          led_out   <= '0;
          grid_out  <= '0;
          score_out <= '0;
        end
      endcase
    end
  end

endmodule
